// File: rtl/seq_fixed_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_fixed_divider_pkg
//   Shared definitions for the multi-cycle arithmetic units.
//   - div_state_e  : FSM state codes for the sequential divider
//   - div_status_e : operation-status encodings (result kind held for the
//                    strobe cycle), reused by the other multi-cycle units
// ---------------------------------------------------------------------------
package seq_fixed_divider_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DVZ   = 3'd3,
        ST_ITER  = 3'd4,
        ST_FIX   = 3'd5,
        ST_DONE  = 3'd6
    } div_state_e;

    typedef enum logic [1:0] {
        STAT_NONE = 2'd0,
        STAT_OK   = 2'd1,
        STAT_OVF  = 2'd2,
        STAT_DVZ  = 2'd3
    } div_status_e;

endpackage

// File: rtl/seq_fixed_divider_iter_datapath.sv
// ---------------------------------------------------------------------------
// div_iter_datapath
//   Restoring-division iteration engine: one quotient bit per step.
//   Holds the divisor magnitude, the combined dividend/quotient shift
//   register, the WIDTH+1-bit partial remainder and the iteration counter.
//   Ports:
//     clk, sclr   clock / synchronous active-high reset
//     load        capture magnitudes, clear remainder, preset counter to N
//     step        perform one restoring iteration
//     a_mag       dividend magnitude (unsigned)
//     b_mag       divisor magnitude (unsigned)
//     ge          current iteration's shifted remainder >= divisor
//     bz          captured divisor magnitude is zero
//     last_iter   the current step is the final one
//     quot        N-bit raw quotient magnitude
//     rem         WIDTH-bit remainder magnitude
// ---------------------------------------------------------------------------
module div_iter_datapath #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    localparam int N    = WIDTH + FRAC,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             ge,
    output logic             bz,
    output logic             last_iter,
    output logic [N-1:0]     quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] bmag_reg;
    logic [N-1:0]     dq_reg;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH:0]   rem_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    // The remainder stays below the divisor after every step, so shifting in
    // one more bit always fits in WIDTH+1 bits.
    assign rem_sh   = (rem_reg << 1) | {{WIDTH{1'b0}}, dq_reg[N-1]};
    assign rem_diff = rem_sh - {1'b0, bmag_reg};
    assign ge       = (rem_sh >= {1'b0, bmag_reg});

    always_ff @(posedge clk) begin
        if (sclr) begin
            bmag_reg <= '0;
            dq_reg   <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            bmag_reg <= b_mag;
            dq_reg   <= N'(a_mag) << FRAC;
            rem_reg  <= '0;
            cnt_reg  <= CW'(N);
        end else if (step) begin
            rem_reg  <= ge ? rem_diff : rem_sh;
            dq_reg   <= {dq_reg[N-2:0], ge};
            cnt_reg  <= cnt_reg - CW'(1);
        end
    end

    assign bz        = (bmag_reg == '0);
    assign last_iter = (cnt_reg == CW'(1));
    assign quot      = dq_reg;
    assign rem       = rem_reg[WIDTH-1:0];

endmodule

// File: rtl/seq_fixed_divider.sv
// ---------------------------------------------------------------------------
// seq_fixed_divider
//   Multi-cycle restoring divider for Q(WIDTH-FRAC).FRAC operands, signed or
//   unsigned, with saturating overflow and divide-by-zero detection.
//   Latency start->strobe is WIDTH+FRAC+4 cycles (3 for divide-by-zero).
//   Ports:
//     clk     clock, rising edge
//     sclr    synchronous active-high reset (highest priority)
//     start   request, sampled only while idle
//     a, b    dividend / divisor, captured in the accept cycle
//     busy    high from the cycle after accept through the strobe cycle
//     valid   one-cycle strobe: q/r hold a correct result
//     ovf     one-cycle strobe: quotient saturated
//     dvz     one-cycle strobe: divisor was zero, q=r=0
//     q, r    quotient / remainder, held until next strobe or reset
// ---------------------------------------------------------------------------
module seq_fixed_divider
    import seq_fixed_divider_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    output logic             dvz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int N = WIDTH + FRAC;

    // Largest representable positive magnitude and the one extra step
    // allowed for a negative result (the most-negative code).
    localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [N-1:0]     NEG_LIM = POS_LIM + N'(1);
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_reg, state_next;
    div_status_e      stat_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sign_reg, aneg_reg;
    logic [WIDTH-1:0] q_reg, r_reg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             ge, bz, last_iter;
    logic [N-1:0]     quot;
    logic [WIDTH-1:0] rem;

    logic [WIDTH-1:0] m_lo;
    logic             ovf_fix;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Magnitudes: negating the most-negative code yields the same bit
    // pattern, which read as unsigned is exactly 2^(WIDTH-1).
    assign a_neg = (SIGNED != 0) && a_reg[WIDTH-1];
    assign b_neg = (SIGNED != 0) && b_reg[WIDTH-1];
    assign a_mag = a_neg ? -a_reg : a_reg;
    assign b_mag = b_neg ? -b_reg : b_reg;

    div_iter_datapath #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_datapath (
        .clk       (clk),
        .sclr      (sclr),
        .load      (state_reg == ST_LOAD),
        .step      (state_reg == ST_ITER),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .ge        (ge),
        .bz        (bz),
        .last_iter (last_iter),
        .quot      (quot),
        .rem       (rem)
    );

    // Overflow detection, sign application and saturation, used in FIX.
    always_comb begin
        m_lo    = quot[WIDTH-1:0];
        ovf_fix = 1'b0;
        q_fix   = m_lo;
        r_fix   = rem;
        if (SIGNED != 0) begin
            ovf_fix = sign_reg ? (quot > NEG_LIM) : (quot > POS_LIM);
            if (ovf_fix)
                q_fix = sign_reg ? Q_MIN : Q_MAX;
            else if (sign_reg)
                q_fix = -m_lo;
            if (aneg_reg)
                r_fix = -rem;
        end else begin
            ovf_fix = (quot >> WIDTH) != '0;
            if (ovf_fix)
                q_fix = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_reg <= ST_IDLE;
            stat_reg  <= STAT_NONE;
            a_reg     <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            aneg_reg  <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                a_reg <= a;
                b_reg <= b;
            end
            if (state_reg == ST_LOAD) begin
                sign_reg <= a_neg ^ b_neg;
                aneg_reg <= a_neg;
            end
            if (state_reg == ST_CHECK && bz) begin
                q_reg    <= '0;
                r_reg    <= '0;
                stat_reg <= STAT_DVZ;
            end
            if (state_reg == ST_FIX) begin
                q_reg    <= q_fix;
                r_reg    <= r_fix;
                stat_reg <= ovf_fix ? STAT_OVF : STAT_OK;
            end
        end
    end

    // Next state and Moore control outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        valid      = 1'b0;
        ovf        = 1'b0;
        dvz        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy       = 1'b1;
                state_next = bz ? ST_DVZ : ST_ITER;
            end
            ST_DVZ: begin
                busy       = 1'b1;
                dvz        = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ITER: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = ST_FIX;
            end
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                valid      = (stat_reg == STAT_OK);
                ovf        = (stat_reg == STAT_OVF);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign q = q_reg;
    assign r = r_reg;

endmodule

// File: tb/tb_seq_fixed_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_fixed_divider
//   Self-checking bench for seq_fixed_divider (WIDTH=16, FRAC=8) with one
//   unsigned and one signed instance. Table of directed vectors run
//   back-to-back, plus sequences for start hammering and mid-op reset.
// ---------------------------------------------------------------------------
module tb_seq_fixed_divider;

    localparam int W = 16;
    localparam int F = 8;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_OVF   = 2;
    localparam int K_DVZ   = 3;

    logic         clk = 1'b0;
    logic         sclr;
    logic         start_u, start_s;
    logic [W-1:0] a, b;

    logic         busy_u, valid_u, ovf_u, dvz_u;
    logic [W-1:0] q_u, r_u;
    logic         busy_s, valid_s, ovf_s, dvz_s;
    logic [W-1:0] q_s, r_s;

    logic         sel_s;
    logic         obs_busy, obs_valid, obs_ovf, obs_dvz;
    logic [W-1:0] obs_q, obs_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_fixed_divider #(.WIDTH(W), .FRAC(F), .SIGNED(0)) u_dut_u (
        .clk(clk), .sclr(sclr), .start(start_u), .a(a), .b(b),
        .busy(busy_u), .valid(valid_u), .ovf(ovf_u), .dvz(dvz_u),
        .q(q_u), .r(r_u)
    );

    seq_fixed_divider #(.WIDTH(W), .FRAC(F), .SIGNED(1)) u_dut_s (
        .clk(clk), .sclr(sclr), .start(start_s), .a(a), .b(b),
        .busy(busy_s), .valid(valid_s), .ovf(ovf_s), .dvz(dvz_s),
        .q(q_s), .r(r_s)
    );

    assign obs_busy  = sel_s ? busy_s  : busy_u;
    assign obs_valid = sel_s ? valid_s : valid_u;
    assign obs_ovf   = sel_s ? ovf_s   : ovf_u;
    assign obs_dvz   = sel_s ? dvz_s   : dvz_u;
    assign obs_q     = sel_s ? q_s     : q_u;
    assign obs_r     = sel_s ? r_s     : r_u;

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           kind;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int strobe_kind();
        int cnt;
        cnt = int'(obs_valid) + int'(obs_ovf) + int'(obs_dvz);
        if (cnt > 1)   return 4;
        if (obs_valid) return K_VALID;
        if (obs_ovf)   return K_OVF;
        if (obs_dvz)   return K_DVZ;
        return K_NONE;
    endfunction

    // Issue one request (start high in the current cycle) and wait for the
    // strobe. Returns at the falling edge of the strobe cycle.
    task automatic run_op(input string tag, input bit s, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int ekind,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int elat, input bit hammer);
        int cyc;
        int kind;
        int busy_bad;
        bit found;
        sel_s = s;
        a = av;
        b = bv;
        if (s) start_s = 1'b1; else start_u = 1'b1;
        @(posedge clk);
        #1;
        if (!hammer) begin
            start_u = 1'b0;
            start_s = 1'b0;
        end
        found    = 1'b0;
        busy_bad = 0;
        kind     = K_NONE;
        cyc      = 1;
        while (!found && cyc <= 60) begin
            if (hammer) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
            kind = strobe_kind();
            if (!obs_busy) busy_bad++;
            if (kind != K_NONE) begin
                found = 1'b1;
            end else begin
                cyc++;
                @(posedge clk);
                #1;
            end
        end
        start_u = 1'b0;
        start_s = 1'b0;
        check({tag, " latency"}, cyc, elat);
        check({tag, " kind"}, kind, ekind);
        check({tag, " q"}, obs_q, eq);
        check({tag, " r"}, obs_r, er);
        check({tag, " busy"}, busy_bad, 0);
        $display("op %s: signed=%0d a=%h b=%h -> kind=%0d q=%h r=%h lat=%0d",
                 tag, s, av, bv, kind, obs_q, obs_r, cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        sclr    = 1'b1;
        start_u = 1'b0;
        start_s = 1'b0;
        a       = '0;
        b       = '0;
        sel_s   = 1'b0;

        //            s     a         b         kind     q         r         lat
        vecs[0]  = '{1'b0, 16'h0300, 16'h0200, K_VALID, 16'h0180, 16'h0000, 28};
        vecs[1]  = '{1'b0, 16'h0100, 16'h0300, K_VALID, 16'h0055, 16'h0100, 28};
        vecs[2]  = '{1'b0, 16'hFF00, 16'h0080, K_OVF,   16'hFFFF, 16'h0000, 28};
        vecs[3]  = '{1'b0, 16'h1234, 16'h0000, K_DVZ,   16'h0000, 16'h0000, 3};
        vecs[4]  = '{1'b0, 16'h0001, 16'h0003, K_VALID, 16'h0055, 16'h0001, 28};
        vecs[5]  = '{1'b0, 16'hFFFF, 16'hFFFF, K_VALID, 16'h0100, 16'h0000, 28};
        vecs[6]  = '{1'b1, 16'hFD00, 16'h0200, K_VALID, 16'hFE80, 16'h0000, 28};
        vecs[7]  = '{1'b1, 16'h8000, 16'hFF00, K_OVF,   16'h7FFF, 16'h0000, 28};
        vecs[8]  = '{1'b1, 16'h8000, 16'h0100, K_VALID, 16'h8000, 16'h0000, 28};
        vecs[9]  = '{1'b1, 16'h0100, 16'hFD00, K_VALID, 16'hFFAB, 16'h0100, 28};
        vecs[10] = '{1'b1, 16'hFF00, 16'h0300, K_VALID, 16'hFFAB, 16'hFF00, 28};
        vecs[11] = '{1'b1, 16'h0000, 16'h0000, K_DVZ,   16'h0000, 16'h0000, 3};
        vecs[12] = '{1'b1, 16'h7FFF, 16'h0001, K_OVF,   16'h7FFF, 16'h0000, 28};
        vecs[13] = '{1'b1, 16'h8000, 16'h0001, K_OVF,   16'h8000, 16'h0000, 28};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        @(negedge clk);
        check("reset busy_u", busy_u, 0);
        check("reset strobes_u", {valid_u, ovf_u, dvz_u}, 0);
        check("reset q_u", q_u, 0);
        check("reset r_u", r_u, 0);
        check("reset busy_s", busy_s, 0);
        check("reset strobes_s", {valid_s, ovf_s, dvz_s}, 0);
        check("reset q_s", q_s, 0);
        check("reset r_s", r_s, 0);
        @(posedge clk);
        #1;

        // Table: each op starts in the idle cycle right after the previous
        // strobe, so per-instance runs are back-to-back.
        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                   vecs[i].kind, vecs[i].q, vecs[i].r, vecs[i].lat, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d idle busy", i), obs_busy, 0);
            check($sformatf("vec%0d idle strobe", i), strobe_kind(), K_NONE);
            check($sformatf("vec%0d q hold", i), obs_q, vecs[i].q);
        end

        // Start pulsed every cycle with changing operands: one strobe only.
        run_op("hammer", 1'b0, 16'h0300, 16'h0200, K_VALID, 16'h0180, 16'h0000, 28, 1'b1);
        strobes = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (strobe_kind() != K_NONE || obs_busy) strobes++;
        end
        check("hammer extra activity", strobes, 0);

        // Reset at cycle 10 of an operation.
        sel_s   = 1'b0;
        a       = 16'h0100;
        b       = 16'h0300;
        start_u = 1'b1;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midreset busy before", busy_u, 1);
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        check("midreset busy", busy_u, 0);
        check("midreset q", q_u, 0);
        check("midreset r", r_u, 0);
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (strobe_kind() != K_NONE || obs_busy) strobes++;
        end
        check("midreset no strobe", strobes, 0);
        run_op("after_reset", 1'b0, 16'h0100, 16'h0300, K_VALID, 16'h0055, 16'h0100, 28, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
